hcsr04_responder: RTL and testbench
===================================

HCSR04_RESPONDER -- requirements
Module: hcsr04_responder

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency (37 ns period).
REQ-002 Parameter MIN_TRIG_CYC, default 270, minimum valid trigger width in cycles (10 us).
REQ-003 Parameter BURST_CYC, default 5400, emulated 8x40 kHz burst delay in cycles (200 us).
REQ-004 Parameter CYC_PER_CM, default 1566, echo cycles per cm round trip (58 us).
REQ-005 Parameter MAX_CM, default 100, largest distance answered with a proportional echo.
REQ-006 Parameter TIMEOUT_CYC, default 1026000, no-target echo width (38 ms).
REQ-007 Parameter HOLDOFF_CYC, default 270000, post-echo dead time (10 ms).
REQ-008 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-010 Port trig, input, 1 bit: asynchronous trigger from the sensor controller.
REQ-011 Port distance_cm, input, 7 bits: emulated target distance, unsigned cm.
REQ-012 Port echo, output, 1 bit: registered echo pulse to the controller.
REQ-013 Port busy, output, 1 bit: high whenever FSM is not IDLE.
REQ-014 Port err_short_trig, output, 1 bit: one-cycle pulse on a rejected short trigger.
REQ-015 Port meas_done, output, 1 bit: one-cycle pulse on the cycle echo falls.

Function
REQ-016 trig SHALL pass a 2-FF synchronizer (trig_s); all edge detection uses trig_s and its 1-cycle delayed copy.
REQ-017 FSM states SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-018 IDLE -> TRIG only on a trig_s rising edge; trig_s already high on entry to IDLE SHALL NOT start a measurement.
REQ-019 TRIG SHALL count trig_s high cycles, saturating at MIN_TRIG_CYC.
REQ-020 On trig_s fall with count >= MIN_TRIG_CYC: -> BURST and latch distance_cm; else -> IDLE and pulse err_short_trig.
REQ-021 BURST SHALL last exactly BURST_CYC cycles, echo low, then -> ECHO.
REQ-022 Echo width SHALL be latched_cm*CYC_PER_CM cycles when 1 <= latched_cm <= MAX_CM, else TIMEOUT_CYC.
REQ-023 Echo rising edge SHALL occur exactly BURST_CYC+3 clock edges after the first edge sampling trig low.
REQ-024 Width product SHALL be computed once at BURST entry into a 21-bit register; no multiplier in the echo path.
REQ-025 Changes on distance_cm after the latch SHALL NOT affect the current echo.
REQ-026 ECHO -> HOLDOFF when width reached; echo low and meas_done high on that same cycle.
REQ-027 trig activity during BURST, ECHO, HOLDOFF SHALL be ignored with no error pulse.
REQ-028 HOLDOFF SHALL last HOLDOFF_CYC cycles, then -> IDLE.
REQ-029 All counters SHALL be 21 bits unsigned and never wrap.

Reset
REQ-030 rst high SHALL immediately force state IDLE, echo 0, busy 0, err_short_trig 0, meas_done 0, counters 0, synchronizer 0, latched distance 0.
REQ-031 Reset asserted mid-ECHO SHALL drop echo without a meas_done pulse; after release a fresh trig rising edge is required.

Structure
REQ-032 Package hcsr04_pkg SHALL hold the FSM state encoding and default timing constants, shared with controller-side testbenches.
REQ-033 Sub-module sync_2ff SHALL implement the synchronizer (rst clears both flops).

Verification
REQ-034 distance_cm=20, trig 300 cycles -> echo rises BURST_CYC+3 edges after trig fall, width 31320 cycles, one meas_done.
REQ-035 trig 100 cycles -> one err_short_trig pulse, echo never rises, busy returns low 3 cycles after trig fall.
REQ-036 distance_cm=0, then separately 101, with 300-cycle trig -> echo width 1026000 cycles each.
REQ-037 distance_cm=50, change to 10 and pulse trig during ECHO -> width stays 78300 cycles, no err pulse.
REQ-038 rst asserted 1000 cycles into ECHO -> echo low immediately, no meas_done; next valid trig yields a normal echo.
REQ-039 trig held high across HOLDOFF end -> no measurement until trig falls and rises again.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// HC-SR04 ultrasonic sensor responder: shared FSM encoding and timing defaults.
// Also used by controller-side benches that emulate or check the sensor.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BURST,
    ECHO,
    HOLDOFF
  } state_e;

  localparam int unsigned CNT_W            = 21;
  localparam int unsigned CLK_HZ_DEF       = 27000000;
  localparam int unsigned MIN_TRIG_CYC_DEF = 270;
  localparam int unsigned BURST_CYC_DEF    = 5400;
  localparam int unsigned CYC_PER_CM_DEF   = 1566;
  localparam int unsigned MAX_CM_DEF       = 100;
  localparam int unsigned TIMEOUT_CYC_DEF  = 1026000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 270000;

  // Out-of-range distances (0 or beyond max_cm) report as "no target".
  function automatic logic [CNT_W-1:0] echo_width(
    input logic [6:0]  cm,
    input int unsigned cyc_per_cm,
    input int unsigned max_cm,
    input int unsigned timeout
  );
    logic [CNT_W-1:0] w;
    if (cm != 7'd0 && 32'(cm) <= max_cm)
      w = CNT_W'(cyc_per_cm) * CNT_W'(cm);
    else
      w = CNT_W'(timeout);
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hcsr04_responder.sv
// Emulates an HC-SR04 sensor: validates trig width, waits the burst time,
// then returns an echo pulse proportional to distance_cm.
module hcsr04_responder
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned MIN_TRIG_CYC = MIN_TRIG_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
  parameter int unsigned MAX_CM       = MAX_CM_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [6:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       err_short_trig,
  output logic       meas_done
);

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_TRIG_CYC);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_CYC);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLDOFF_CYC);

  if (CLK_HZ == 0) begin : g_bad_clk
    $error("hcsr04_responder: CLK_HZ must be nonzero");
  end

  logic trig_s;
  logic trig_prev_q, trig_prev_d;
  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [6:0]       cm_q, cm_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (trig),
    .q   (trig_s)
  );

  assign rise = trig_s & ~trig_prev_q;
  assign fall = ~trig_s & trig_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    cm_d        = cm_q;
    err_d       = 1'b0;
    trig_prev_d = trig_s;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = TRIG;
          cnt_d   = CNT_W'(1);
        end
      end
      TRIG: begin
        if (fall) begin
          cnt_d = '0;
          if (cnt_q >= MIN_C) begin
            state_d = BURST;
            cm_d    = distance_cm;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (cnt_q < MIN_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BURST: begin
        // Width is fixed here so the echo path only compares.
        if (cnt_q == '0)
          width_d = echo_width(cm_q, CYC_PER_CM, MAX_CM, TIMEOUT_CYC);
        if (cnt_q + CNT_W'(1) >= BURST_C) begin
          state_d = ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt_q + CNT_W'(1) >= width_q) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q + CNT_W'(1) >= HOLD_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, one cycle behind it.
  always_comb begin
    echo_d = (state_q == ECHO);
    busy_d = (state_q != IDLE);
    done_d = echo_q & (state_q != ECHO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      cm_q        <= '0;
      trig_prev_q <= 1'b0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      cm_q        <= cm_d;
      trig_prev_q <= trig_prev_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign echo           = echo_q;
  assign busy           = busy_q;
  assign err_short_trig = err_q;
  assign meas_done      = done_q;

endmodule

// File: tb/tb_hcsr04_responder.sv
// Scoreboard bench for hcsr04_responder with scaled-down timing.
// Stimulus pushes expected echo/error events; a negedge monitor checks them.
module tb_hcsr04_responder;

  localparam int B    = 50;
  localparam int MINT = 10;
  localparam int CPC  = 7;
  localparam int MAXC = 100;
  localparam int TO   = 900;
  localparam int HOLD = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [6:0] distance_cm;
  logic       echo, busy, err_short_trig, meas_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int t;
    int w;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  hcsr04_responder #(
    .CLK_HZ       (27000000),
    .MIN_TRIG_CYC (MINT),
    .BURST_CYC    (B),
    .CYC_PER_CM   (CPC),
    .MAX_CM       (MAXC),
    .TIMEOUT_CYC  (TO),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trig           (trig),
    .distance_cm    (distance_cm),
    .echo           (echo),
    .busy           (busy),
    .err_short_trig (err_short_trig),
    .meas_done      (meas_done)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Sensor behaviour straight from the datasheet-style rules.
  function automatic int model_width(input int cm);
    if (cm >= 1 && cm <= MAXC) return cm * CPC;
    return TO;
  endfunction

  logic echo_p = 1'b0;
  int   rise_at = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      echo_p <= 1'b0;
    end else begin
      if (echo && !echo_p) rise_at <= cyc;
      if (!echo && echo_p) begin
        chk("done_on_fall", int'(meas_done), 1);
        if (q.size() == 0) begin
          chk("echo_expected", 0, 1);
        end else begin
          e = q.pop_front();
          chk("echo_kind", int'(e.is_err), 0);
          chk("echo_rise", rise_at, e.t);
          chk("echo_width", cyc - rise_at, e.w);
        end
      end else if (meas_done) begin
        chk("stray_done", 1, 0);
      end
      if (err_short_trig) begin
        if (q.size() == 0) begin
          chk("err_expected", 0, 1);
        end else begin
          e = q.pop_front();
          chk("err_kind", int'(e.is_err), 1);
          chk("err_time", cyc, e.t);
        end
      end
      echo_p <= echo;
    end
  end

  task automatic pulse(input int cm, input int n, input bit push, output int k);
    exp_t e;
    @(posedge clk);
    #1;
    distance_cm = 7'(cm);
    trig = 1'b1;
    repeat (n) @(posedge clk);
    #1 trig = 1'b0;
    k = cyc;
    if (push) begin
      if (n >= MINT) begin
        e.is_err = 1'b0;
        e.t = k + B + 4;
        e.w = model_width(cm);
      end else begin
        e.is_err = 1'b1;
        e.t = k + 3;
        e.w = 0;
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_echo();
    int n = 0;
    while (!echo && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!echo) chk("echo_timeout", 0, 1);
  endtask

  task automatic meas(input int cm, input int n);
    int k;
    pulse(cm, n, 1'b1, k);
    repeat (5) @(posedge clk);
    #1 distance_cm = 7'($urandom_range(0, 127));
    wait_idle();
  endtask

  initial begin
    int k;
    int cnt;
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_short_trig), 0);
    chk("rst_done", int'(meas_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    meas(20, 30);

    pulse(20, 5, 1'b1, k);
    while (cyc < k + 3) @(negedge clk);
    chk("short_busy_hi", int'(busy), 1);
    @(negedge clk);
    chk("short_busy_lo", int'(busy), 0);
    wait_idle();

    meas(30, MINT - 1);
    meas(30, MINT);
    meas(0, 30);
    meas(101, 30);
    meas(100, 30);
    meas(1, 30);
    meas(127, 30);

    pulse(50, 30, 1'b1, k);
    wait_echo();
    #1 distance_cm = 7'd10;
    pulse(10, 15, 1'b0, k);
    wait_idle();

    pulse(40, 30, 1'b0, k);
    wait_echo();
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_echo", int'(echo), 0);
    chk("midrst_done", int'(meas_done), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    meas(40, 30);

    pulse(25, 30, 1'b1, k);
    wait_echo();
    @(posedge clk);
    #1 trig = 1'b1;
    wait_idle();
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("held_trig_no_start", cnt, 0);
    @(posedge clk);
    #1 trig = 1'b0;
    repeat (5) @(posedge clk);
    meas(25, 30);

    for (int i = 0; i < 10; i++) begin
      meas(int'($urandom_range(0, 127)), int'($urandom_range(3, 25)));
    end

    repeat (10) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
